perf_stat_collector: RTL and testbench
======================================

PERF_STAT_COLLECTOR -- requirements
Module: perf_stat_collector

Interface
REQ-001 Parameter CNT_W, default 32, width of every event counter (legal 8..32).
REQ-002 Parameter HALT_ON_ECALL, default 1, when 1 a stat_ecall pulse moves the FSM to HALT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; moves FSM from IDLE to RUN.
REQ-006 clr  input  1  synchronous clear of all counters, saturation flags and sticky warnings.
REQ-007 stat_beq, stat_bne, stat_blt, stat_bge, stat_bltu, stat_bgeu  input  1 each  CPU branch-resolved event strobes.
REQ-008 stat_jal, stat_jalr, stat_PL_flush, stat_PL_stall, stat_PL_stall_inner, stat_ecall  input  1 each  CPU jump/pipeline/ecall event strobes.
REQ-009 Rd_x_warning_ram, unknown_instr_warning_main_decode  input  1 each  warning levels from memory and decoder.
REQ-010 rd_en  input  1  read request, one per cycle.
REQ-011 rd_sel  input  4  counter/register index.
REQ-012 rd_data  output  32  read result, counters zero-extended from CNT_W.
REQ-013 rd_valid  output  1  qualifies rd_data.
REQ-014 running  output  1  high when FSM is in RUN.

Function
REQ-015 FSM states IDLE=2'b00, RUN=2'b01, HALT=2'b10; 2'b11 unused, recovers to IDLE next cycle.
REQ-016 IDLE -> RUN when start=1; RUN -> HALT when stat_ecall=1 and HALT_ON_ECALL=1; HALT -> IDLE when clr=1; no other transitions.
REQ-017 clr in RUN clears counters but keeps state RUN; clr in IDLE clears and stays IDLE.
REQ-018 Counters increment only while state is RUN in the cycle the strobe is sampled.
REQ-019 Index map: 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu, 6 jal, 7 jalr, 8 PL_flush, 9 PL_stall, 10 PL_stall_inner, 11 ecall.
REQ-020 Index 12 cycle counter: +1 every RUN cycle.
REQ-021 Index 13 branch total: +1 per RUN cycle in which any of indices 0..5 strobes is high (+1 max per cycle).
REQ-022 Index 14 status: bit0 sticky Rd_x_warning_ram, bit1 sticky unknown_instr_warning_main_decode, bits3:2 FSM state, bit4 any counter saturated, bits31:5 zero.
REQ-023 Index 15 reads 32'h0.
REQ-024 Sticky warnings set on any cycle the input is high, in any state; cleared only by clr or rst.
REQ-025 Counters saturate at all-ones of CNT_W; once saturated hold value, bit4 of status sets and stays until clr/rst.
REQ-026 Read latency exactly 1 cycle: rd_en at edge N -> rd_valid=1 and rd_data after edge N+1, for exactly one cycle per request.
REQ-027 rd_data returns the value held before edge N (increment in same cycle not visible); back-to-back reads each yield one valid cycle.
REQ-028 rd_en=0 -> rd_valid=0 next cycle; rd_data holds last value.
REQ-029 clr and an event in the same cycle: clr wins, counter ends at 0; clr and warning same cycle: sticky bit ends at 0.
REQ-030 stat_ecall in the HALT transition cycle is counted (index 11 +1, cycle counter +1); nothing counts in HALT.
REQ-031 running = (state==RUN), registered.

Reset
REQ-032 rst=1 asynchronously forces state IDLE, all counters 0, sticky and saturation flags 0, rd_valid=0, rd_data=0, running=0.
REQ-033 Reset asserted mid-read discards the pending read; no rd_valid after release.
REQ-034 After rst release, FSM stays IDLE until start.

Verification
REQ-035 Reset, start=1, 10 cycles with stat_beq high 3 cycles -> read sel 0 gives 3, sel 13 gives 3, sel 12 gives 10.
REQ-036 CNT_W=8, stat_PL_stall high 300 RUN cycles -> sel 9 reads 255, sel 14 bit4=1; clr -> sel 9 reads 0, bit4=0.
REQ-037 HALT_ON_ECALL=1, stat_ecall pulse in RUN -> running=0 next cycle, sel 11 reads 1, sel 14 bits3:2=2'b10; further strobes uncounted.
REQ-038 clr and stat_jal high same RUN cycle with sel 6 at 5 -> sel 6 reads 0.
REQ-039 unknown_instr_warning_main_decode pulsed in IDLE -> sel 14 bit1=1; rd_en/rd_sel=14 at edge N -> rd_valid only after N+1.
REQ-040 rst asserted between rd_en and next edge -> rd_valid stays 0, all reads afterward return 0 except sel 14 reflects IDLE.

Source files
------------

// File: rtl/perf_stat_collector.sv
// CPU performance-event counters with RUN/HALT control, sticky warnings and a
// one-cycle-latency register read port.
`timescale 1ns/1ps
module perf_stat_collector #(
    parameter int CNT_W         = 32,
    parameter int HALT_ON_ECALL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clr,
    input  logic        stat_beq,
    input  logic        stat_bne,
    input  logic        stat_blt,
    input  logic        stat_bge,
    input  logic        stat_bltu,
    input  logic        stat_bgeu,
    input  logic        stat_jal,
    input  logic        stat_jalr,
    input  logic        stat_PL_flush,
    input  logic        stat_PL_stall,
    input  logic        stat_PL_stall_inner,
    input  logic        stat_ecall,
    input  logic        Rd_x_warning_ram,
    input  logic        unknown_instr_warning_main_decode,
    input  logic        rd_en,
    input  logic [3:0]  rd_sel,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        running
);
    // state | meaning
    // IDLE  | waiting for start, nothing counts
    // RUN   | events and cycles are counted
    // HALT  | stopped by ecall, waits for clr to return to IDLE
    // BAD   | unreachable encoding, recovers to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        BAD  = 2'b11
    } state_t;

    localparam int N_CNT = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt [N_CNT];
    logic [N_CNT-1:0] evt;
    logic [N_CNT-1:0] sat_hit;
    logic [1:0]       sticky;
    logic             sat_flag;
    logic [31:0]      rd_mux;
    logic             any_branch;

    assign any_branch = stat_beq | stat_bne | stat_blt | stat_bge | stat_bltu | stat_bgeu;
    // Index 12 is the cycle counter (always enabled), index 13 the branch total.
    assign evt = {any_branch, 1'b1, stat_ecall, stat_PL_stall_inner, stat_PL_stall,
                  stat_PL_flush, stat_jalr, stat_jal, stat_bgeu, stat_bltu,
                  stat_bge, stat_blt, stat_bne, stat_beq};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!clr && start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!clr && (HALT_ON_ECALL != 0) && stat_ecall) begin
                        state   <= HALT;
                        running <= 1'b0;
                    end
                end
                HALT: begin
                    if (clr) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sat_hit = '0;
        for (int i = 0; i < N_CNT; i++) begin
            sat_hit[i] = (state == RUN) && evt[i] && (cnt[i] == CNT_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CNT; i++) cnt[i] <= '0;
            sat_flag <= 1'b0;
            sticky   <= 2'b00;
        end else if (clr) begin
            for (int i = 0; i < N_CNT; i++) cnt[i] <= '0;
            sat_flag <= 1'b0;
            sticky   <= 2'b00;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                if ((state == RUN) && evt[i] && (cnt[i] != CNT_MAX))
                    cnt[i] <= cnt[i] + 1'b1;
            end
            if (|sat_hit) sat_flag <= 1'b1;
            if (Rd_x_warning_ram) sticky[0] <= 1'b1;
            if (unknown_instr_warning_main_decode) sticky[1] <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        if (rd_sel < 4'd14)
            rd_mux[CNT_W-1:0] = cnt[rd_sel];
        else if (rd_sel == 4'd14)
            rd_mux = {27'h0, sat_flag, state, sticky};
    end

    // Data is captured from pre-edge register values, so same-cycle increments are not visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= 32'h0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_perf_stat_collector.sv
// Scoreboard bench for perf_stat_collector (CNT_W=8 so saturation is reachable).
`timescale 1ns/1ps
module tb_perf_stat_collector;
    logic        clk = 1'b0;
    logic        rst, start, clr;
    logic        stat_beq, stat_bne, stat_blt, stat_bge, stat_bltu, stat_bgeu;
    logic        stat_jal, stat_jalr, stat_PL_flush, stat_PL_stall, stat_PL_stall_inner, stat_ecall;
    logic        Rd_x_warning_ram, unknown_instr_warning_main_decode;
    logic        rd_en;
    logic [3:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_valid, running;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    perf_stat_collector #(.CNT_W(8), .HALT_ON_ECALL(1)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr),
        .stat_beq(stat_beq), .stat_bne(stat_bne), .stat_blt(stat_blt), .stat_bge(stat_bge),
        .stat_bltu(stat_bltu), .stat_bgeu(stat_bgeu), .stat_jal(stat_jal), .stat_jalr(stat_jalr),
        .stat_PL_flush(stat_PL_flush), .stat_PL_stall(stat_PL_stall),
        .stat_PL_stall_inner(stat_PL_stall_inner), .stat_ecall(stat_ecall),
        .Rd_x_warning_ram(Rd_x_warning_ram),
        .unknown_instr_warning_main_decode(unknown_instr_warning_main_decode),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] sel, input logic [31:0] exp, input string tag);
        rd_en  = 1'b1;
        rd_sel = sel;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, {31'h0, rd_valid}, 32'h1);
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'h1, 32'h0);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string t = tag_q.pop_front();
                chk(t, rd_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 0; clr = 0;
        {stat_beq, stat_bne, stat_blt, stat_bge, stat_bltu, stat_bgeu} = '0;
        {stat_jal, stat_jalr, stat_PL_flush, stat_PL_stall, stat_PL_stall_inner, stat_ecall} = '0;
        Rd_x_warning_ram = 0; unknown_instr_warning_main_decode = 0;
        rd_en = 0; rd_sel = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_running", {31'h0, running}, 32'h0);
        chk("rst_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_data", rd_data, 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_hold", {31'h0, running}, 32'h0);
        rd(4'd14, 32'h0, "idle_status");

        // basic counting
        start = 1'b1; tick(); start = 1'b0;
        chk("run_on", {31'h0, running}, 32'h1);
        stat_beq = 1'b1; repeat (3) tick(); stat_beq = 1'b0;
        repeat (7) tick();
        rd(4'd12, 32'd10, "cyc10");
        rd(4'd0, 32'd3, "beq3");
        rd(4'd13, 32'd3, "br_tot3");

        // clr beats a same-cycle event
        stat_jal = 1'b1; repeat (5) tick(); stat_jal = 1'b0;
        rd(4'd6, 32'd5, "jal5");
        clr = 1'b1; stat_jal = 1'b1; tick(); clr = 1'b0; stat_jal = 1'b0;
        chk("clr_keeps_run", {31'h0, running}, 32'h1);
        rd(4'd6, 32'd0, "jal_clr");
        rd(4'd12, 32'd1, "cyc_after_clr");
        rd(4'd0, 32'd0, "beq_clr");

        // saturation at 8 bits
        stat_PL_stall = 1'b1; repeat (300) tick(); stat_PL_stall = 1'b0;
        rd(4'd9, 32'd255, "stall_sat");
        rd(4'd14, 32'h14, "status_sat_run");
        rd(4'd10, 32'd0, "inner0");

        // ecall halts; nothing counts in HALT
        stat_ecall = 1'b1; tick(); stat_ecall = 1'b0;
        chk("halt_running", {31'h0, running}, 32'h0);
        stat_beq = 1; stat_jal = 1; stat_ecall = 1; stat_jalr = 1;
        repeat (4) tick();
        stat_beq = 0; stat_jal = 0; stat_ecall = 0; stat_jalr = 0;
        rd(4'd11, 32'd1, "ecall1");
        rd(4'd14, 32'h18, "status_halt");
        rd(4'd6, 32'd0, "jal_halt");
        rd(4'd7, 32'd0, "jalr_halt");
        rd(4'd13, 32'd0, "br_halt");
        rd(4'd15, 32'd0, "sel15");

        // clr in HALT returns to IDLE and clears everything
        clr = 1'b1; tick(); clr = 1'b0;
        chk("idle_after_clr", {31'h0, running}, 32'h0);
        rd(4'd9, 32'd0, "stall_clr");
        rd(4'd14, 32'h0, "status_clr");
        rd(4'd12, 32'd0, "cyc_idle");

        // sticky warnings and read latency
        Rd_x_warning_ram = 1'b1; clr = 1'b1; tick(); Rd_x_warning_ram = 1'b0; clr = 1'b0;
        unknown_instr_warning_main_decode = 1'b1; tick(); unknown_instr_warning_main_decode = 1'b0;
        rd_en = 1'b1; rd_sel = 4'd14;
        chk("lat_pre", {31'h0, rd_valid}, 32'h0);
        exp_q.push_back(32'h2); tag_q.push_back("warn_unk");
        tick(); rd_en = 1'b0;
        chk("lat_post", {31'h0, rd_valid}, 32'h1);
        tick();
        chk("vld_drop", {31'h0, rd_valid}, 32'h0);
        chk("data_hold", rd_data, 32'h2);
        Rd_x_warning_ram = 1'b1; tick(); Rd_x_warning_ram = 1'b0;
        rd(4'd14, 32'h3, "warn_both");

        // reset during a pending read
        start = 1'b1; tick(); start = 1'b0;
        stat_beq = 1'b1; repeat (3) tick(); stat_beq = 1'b0;
        rd_en = 1'b1; rd_sel = 4'd0;
        #2 rst = 1'b1;
        #1;
        rd_en = 1'b0;
        chk("rst_mid_data", rd_data, 32'h0);
        chk("rst_mid_run", {31'h0, running}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_no_valid", {31'h0, rd_valid}, 32'h0);
        repeat (2) tick();
        rd(4'd0, 32'd0, "beq_rst");
        rd(4'd12, 32'd0, "cyc_rst");
        rd(4'd13, 32'd0, "br_rst");
        rd(4'd14, 32'h0, "status_rst");

        repeat (2) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
